// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read-domain pointers, wptr synchronizer, empty/level flags
// Optional sticky underflow flag enabled by macro FIFO_RD_UNDERFLOW_EN.
module fifo_rd_ctrl #(
  parameter int ADDR_SIZE     = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 rinc,
  input  logic [ADDR_SIZE:0]   wptr,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic [ADDR_SIZE:0]   rptr,
  output logic                 rempty,
  output logic                 raempty,
  output logic [ADDR_SIZE:0]   rlevel,
  output logic                 runderflow
);

  localparam int PTR_W = ADDR_SIZE + 1;
  localparam logic [PTR_W-1:0] THRESH = PTR_W'(AEMPTY_THRESH);

  logic [PTR_W-1:0] rq1_wptr_q, rq2_wptr_q;
  logic [PTR_W-1:0] rbin_q, rbin_d;
  logic [PTR_W-1:0] rptr_q, rgray_d;
  logic [PTR_W-1:0] rlevel_q, level_d;
  logic [PTR_W-1:0] wbin_s;
  logic             rempty_q, rempty_d;
  logic             raempty_q, raempty_d;
  logic             pop;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rq1_wptr_q <= '0;
      rq2_wptr_q <= '0;
    end else begin
      rq1_wptr_q <= wptr;
      rq2_wptr_q <= rq1_wptr_q;
    end
  end

  // Bit i of the binary value is the XOR of Gray bits i and above.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i < PTR_W; i++) begin
      wbin_s[i] = ^(rq2_wptr_q >> i);
    end
  end

  always_comb begin
    pop       = rinc & ~rempty_q;
    rbin_d    = rbin_q + {{ADDR_SIZE{1'b0}}, pop};
    rgray_d   = (rbin_d >> 1) ^ rbin_d;
    level_d   = wbin_s - rbin_d;
    rempty_d  = (rgray_d == rq2_wptr_q);
    raempty_d = (level_d <= THRESH);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rgray_d;
      rlevel_q  <= level_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
    end
  end

`ifdef FIFO_RD_UNDERFLOW_EN
  logic runderflow_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      runderflow_q <= 1'b0;
    end else if (rinc & rempty_q) begin
      runderflow_q <= 1'b1;
    end
  end

  assign runderflow = runderflow_q;
`else
  assign runderflow = 1'b0;
`endif

  assign raddr   = rbin_q[ADDR_SIZE-1:0];
  assign rptr    = rptr_q;
  assign rempty  = rempty_q;
  assign raempty = raempty_q;
  assign rlevel  = rlevel_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - directed and random checks of fifo_rd_ctrl against a counting model
module tb_fifo_rd_ctrl;

  localparam int AS    = 4;
  localparam int PW    = AS + 1;
  localparam int DEPTH = 1 << AS;
  localparam int TH    = 2;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          rinc;
  logic [PW-1:0] wptr;
  logic [AS-1:0] raddr;
  logic [PW-1:0] rptr;
  logic          rempty;
  logic          raempty;
  logic [PW-1:0] rlevel;
  logic          runderflow;

  fifo_rd_ctrl #(.ADDR_SIZE(AS), .AEMPTY_THRESH(TH)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rinc       (rinc),
    .wptr       (wptr),
    .raddr      (raddr),
    .rptr       (rptr),
    .rempty     (rempty),
    .raempty    (raempty),
    .rlevel     (rlevel),
    .runderflow (runderflow)
  );

  always #5 rclk = ~rclk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: total writes/reads as plain integers, writes seen after sync delay.
  int   wcnt, rcnt, seen1, seen2, m_level;
  bit   m_empty, m_aempty, m_uflow;
  logic [7:0] mem [DEPTH];
  logic [7:0] sb [$];

  function automatic logic [PW-1:0] gray(input int n);
    logic [PW-1:0] b;
    b = PW'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wcnt = 0; rcnt = 0; seen1 = 0; seen2 = 0; m_level = 0;
    m_empty = 1'b1; m_aempty = 1'b1; m_uflow = 1'b0;
    sb.delete();
  endtask

  task automatic chk_all(input string tag);
    bit exp_uf;
`ifdef FIFO_RD_UNDERFLOW_EN
    exp_uf = m_uflow;
`else
    exp_uf = 1'b0;
`endif
    chk({tag, "_rempty"},  32'(rempty),     32'(m_empty));
    chk({tag, "_raempty"}, 32'(raempty),    32'(m_aempty));
    chk({tag, "_rlevel"},  32'(rlevel),     32'(m_level));
    chk({tag, "_raddr"},   32'(raddr),      32'(rcnt % DEPTH));
    chk({tag, "_rptr"},    32'(rptr),       32'(gray(rcnt)));
    chk({tag, "_uflow"},   32'(runderflow), 32'(exp_uf));
  endtask

  task automatic do_write();
    logic [7:0] d;
    d = 8'($urandom);
    mem[wcnt % DEPTH] = d;
    sb.push_back(d);
    wcnt++;
    wptr = gray(wcnt);
  endtask

  task automatic tick(input string tag);
    bit         pop;
    logic [7:0] exp_d;
    pop = rinc && !m_empty;
    if (rinc && m_empty) m_uflow = 1'b1;
    if (pop) begin
      exp_d = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      chk({tag, "_data"}, 32'(mem[raddr]), 32'(exp_d));
    end
    rcnt    += int'(pop);
    m_level  = seen2 - rcnt;
    m_empty  = (m_level == 0);
    m_aempty = (m_level <= TH);
    seen2    = seen1;
    seen1    = wcnt;
    @(posedge rclk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    logic [PW-1:0] save_ptr;
    logic [AS-1:0] save_addr, prev_addr;
    int            tgt_w, tgt_r, budget;
    bit            saw_wrap;

    rrst_n = 1'b0;
    rinc   = 1'b0;
    wptr   = '0;
    model_reset();
    repeat (2) @(posedge rclk);
    #1;
    chk_all("reset");
    rrst_n = 1'b1;

    // First write: empty clears on the 3rd edge.
    do_write();
    tick("fw1");
    chk("fw1_empty", 32'(rempty), 32'd1);
    tick("fw2");
    chk("fw2_empty", 32'(rempty), 32'd1);
    tick("fw3");
    chk("fw3_empty", 32'(rempty), 32'd0);
    chk("fw3_level", 32'(rlevel), 32'd1);
    chk("fw3_aempty", 32'(raempty), 32'd1);

    // Fill to 16 and drain back-to-back.
    while (wcnt < DEPTH) do_write();
    repeat (3) tick("fill");
    chk("fill_level", 32'(rlevel), 32'd16);
    chk("fill_aempty", 32'(raempty), 32'd0);
    rinc = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_raddr", 32'(raddr), 32'(i));
      tick("drain");
      if (i == 12) chk("drain_lvl3_aempty", 32'(raempty), 32'd0);
      if (i == 13) chk("drain_lvl2_aempty", 32'(raempty), 32'd1);
    end
    chk("drain_empty", 32'(rempty), 32'd1);
    chk("drain_rptr", 32'(rptr), 32'b11000);

    // Read while empty is ignored.
    save_ptr  = rptr;
    save_addr = raddr;
    tick("eread");
    chk("eread_rptr", 32'(rptr), 32'(save_ptr));
    chk("eread_raddr", 32'(raddr), 32'(save_addr));
    rinc = 1'b0;
    tick("eread_hold");

    // Pop lands on the edge where the second write becomes visible.
    do_write();
    repeat (3) tick("sim_a");
    do_write();
    tick("sim_b");
    tick("sim_c");
    rinc = 1'b1;
    tick("sim_pop");
    rinc = 1'b0;
    chk("sim_empty", 32'(rempty), 32'd0);
    chk("sim_level", 32'(rlevel), 32'd1);

    // Random streaming with wrap-around.
    tgt_w    = wcnt + 40;
    tgt_r    = tgt_w;
    budget   = 3000;
    saw_wrap = 1'b0;
    while ((wcnt < tgt_w || rcnt < tgt_r) && budget > 0) begin
      if (wcnt < tgt_w && (wcnt - rcnt) < DEPTH && $urandom_range(0, 9) < 6) do_write();
      rinc = ($urandom_range(0, 9) < 6);
      prev_addr = raddr;
      tick("rnd");
      if (prev_addr == 4'd15 && raddr == 4'd0) saw_wrap = 1'b1;
      budget--;
    end
    rinc = 1'b0;
    repeat (3) tick("rnd_tail");
    chk("rnd_reads_done", 32'(rcnt), 32'(tgt_r));
    chk("rnd_wrap_seen", 32'(saw_wrap), 32'd1);

    // Asynchronous reset in the middle of traffic.
    repeat (5) do_write();
    repeat (3) tick("mid_a");
    rinc = 1'b1;
    repeat (2) tick("mid_b");
    #3;
    rrst_n = 1'b0;
    #1;
    model_reset();
    wptr = '0;
    rinc = 1'b0;
    chk_all("arst");
    chk("arst_rempty", 32'(rempty), 32'd1);
    chk("arst_rlevel", 32'(rlevel), 32'd0);
    @(posedge rclk);
    #1;
    chk_all("arst_held");
    rrst_n = 1'b1;
    tick("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
